tx_frame_scheduler: RTL

TX_FRAME_SCHEDULER -- requirements
Module: tx_frame_scheduler

---
 rtl/tx_frame_scheduler_pkg.sv | 36 +++
 rtl/tx_frame_scheduler_if.sv | 14 +
 rtl/tx_frame_scheduler_frame_byte_sel.sv | 54 +++++
 rtl/tx_frame_scheduler.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/tx_frame_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// tx_frame_scheduler_pkg : shared constants, FSM encoding and snapshot type
// Rev 1.0 - initial release
// ============================================================================
package tx_frame_scheduler_pkg;

    localparam logic [7:0] c_HDR_SAMPLE_DEF = 8'hA5;
    localparam logic [7:0] c_HDR_ALARM_DEF  = 8'h5A;

    localparam int c_FRAME_LEN_TS   = 6;
    localparam int c_FRAME_LEN_BASE = 3;
`ifdef TX_TIMESTAMP_EN
    localparam int c_FRAME_LEN = c_FRAME_LEN_TS;
`else
    localparam int c_FRAME_LEN = c_FRAME_LEN_BASE;
`endif

    localparam int c_IDX_W = 3;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [4:0] hours;
        logic [5:0] minutes;
        logic [5:0] seconds;
    } time_snap_t;

endpackage
`default_nettype wire

// File: rtl/tx_frame_scheduler_if.sv
`default_nettype none
// ============================================================================
// tx_frame_scheduler_if : byte handshake between the scheduler and a UART TX
// Rev 1.0 - initial release
// ============================================================================
interface tx_frame_scheduler_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;

    modport master (output tx_data, output tx_start, input tx_busy);
    modport slave  (input tx_data, input tx_start, output tx_busy);
endinterface
`default_nettype wire

// File: rtl/tx_frame_scheduler_frame_byte_sel.sv
`default_nettype none
// ============================================================================
// frame_byte_sel : combinational byte mux and checksum for one frame
// Rev 1.0 - initial release (time bytes present when TX_TIMESTAMP_EN defined)
// ============================================================================
module frame_byte_sel
    import tx_frame_scheduler_pkg::*;
(
    input  wire [c_IDX_W-1:0] i_idx,
    input  wire [7:0]         i_header,
    input  wire [7:0]         i_temp,
    input  wire time_snap_t   i_snap,
    output logic [7:0]        o_byte,
    output logic [7:0]        o_checksum
);

`ifdef TX_TIMESTAMP_EN
    logic [7:0] w_hours;
    logic [7:0] w_minutes;
    logic [7:0] w_seconds;

    assign w_hours    = {3'b000, i_snap.hours};
    assign w_minutes  = {2'b00, i_snap.minutes};
    assign w_seconds  = {2'b00, i_snap.seconds};
    assign o_checksum = i_header ^ i_temp ^ w_hours ^ w_minutes ^ w_seconds;

    always_comb begin
        o_byte = o_checksum;
        case (i_idx)
            3'd0:    o_byte = i_header;
            3'd1:    o_byte = i_temp;
            3'd2:    o_byte = w_hours;
            3'd3:    o_byte = w_minutes;
            3'd4:    o_byte = w_seconds;
            default: o_byte = o_checksum;
        endcase
    end
`else
    logic w_unused_snap;
    assign w_unused_snap = ^i_snap;
    assign o_checksum    = i_header ^ i_temp;

    always_comb begin
        o_byte = o_checksum;
        case (i_idx)
            3'd0:    o_byte = i_header;
            3'd1:    o_byte = i_temp;
            default: o_byte = o_checksum;
        endcase
    end
`endif

endmodule
`default_nettype wire

// File: rtl/tx_frame_scheduler.sv
`default_nettype none
// ============================================================================
// tx_frame_scheduler : packs temperature/alarm samples into UART byte frames
// Rev 1.0 - initial release; TX_TIMESTAMP_EN adds hh:mm:ss bytes to frames
// ============================================================================
module tx_frame_scheduler
    import tx_frame_scheduler_pkg::*;
#(
    parameter logic [7:0] HDR_SAMPLE  = c_HDR_SAMPLE_DEF,
    parameter logic [7:0] HDR_ALARM   = c_HDR_ALARM_DEF,
    parameter int         ACK_TIMEOUT = 16
) (
    input  wire                   clk,
    input  wire                   reset,
    input  wire  [7:0]            temp,
    input  wire                   pulse,
    input  wire                   alarm,
    input  wire                   shutdown,
    input  wire  [5:0]            seconds,
    input  wire  [5:0]            minutes,
    input  wire  [4:0]            hours,
    tx_frame_scheduler_if.master  tx,
    output logic                  frame_active,
    output logic [7:0]            drop_count,
    output logic                  ack_error
);

    localparam logic [15:0] c_TIMEOUT_LAST = 16'(ACK_TIMEOUT - 1);

    state_t             r_state;
    logic [c_IDX_W-1:0] r_idx;
    logic [15:0]        r_cnt;
    logic               r_alarm_q;
    logic               r_samp_pend;
    logic               r_alarm_pend;
    logic [7:0]         r_samp_temp;
    logic [7:0]         r_alarm_temp;
    logic [7:0]         r_hdr;
    logic [7:0]         r_ftemp;
    logic               r_tx_start;
    logic [7:0]         r_tx_data;
    logic [7:0]         r_drop;
    logic               r_ack_err;

    logic               w_alarm_rise;
    logic               w_can_start;
    logic               w_start_alarm;
    logic               w_start_sample;
    logic [c_IDX_W-1:0] w_next_idx;
    logic [7:0]         w_byte;
    logic [7:0]         w_checksum;
    time_snap_t         w_snap;

    assign w_alarm_rise   = alarm & ~r_alarm_q;
    assign w_can_start    = (r_state == ST_IDLE) && !shutdown;
    assign w_start_alarm  = w_can_start && r_alarm_pend;
    assign w_start_sample = w_can_start && !r_alarm_pend && r_samp_pend;
    assign w_next_idx     = r_idx + 3'd1;

`ifdef TX_TIMESTAMP_EN
    time_snap_t r_snap;
    time_snap_t w_live_snap;
    assign w_live_snap = {hours, minutes, seconds};
    assign w_snap      = r_snap;

    // Time is frozen at frame start so a seconds rollover cannot tear a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_snap <= '0;
        end else if (w_start_alarm || w_start_sample) begin
            r_snap <= w_live_snap;
        end
    end
`else
    logic w_unused_time;
    assign w_unused_time = ^{hours, minutes, seconds};
    assign w_snap        = '0;
`endif

    frame_byte_sel u_byte_sel (
        .i_idx      (w_next_idx),
        .i_header   (r_hdr),
        .i_temp     (r_ftemp),
        .i_snap     (w_snap),
        .o_byte     (w_byte),
        .o_checksum (w_checksum)
    );

    // Request capture; a new pulse beats the clear of a frame that starts now.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_alarm_q    <= 1'b0;
            r_alarm_pend <= 1'b0;
            r_samp_pend  <= 1'b0;
            r_alarm_temp <= 8'h00;
            r_samp_temp  <= 8'h00;
            r_drop       <= 8'h00;
        end else begin
            r_alarm_q <= alarm;
            if (w_alarm_rise) begin
                r_alarm_pend <= 1'b1;
                r_alarm_temp <= temp;
            end else if (w_start_alarm) begin
                r_alarm_pend <= 1'b0;
            end

            if (shutdown) begin
                r_samp_pend <= 1'b0;
            end else if (pulse) begin
                r_samp_pend <= 1'b1;
                r_samp_temp <= temp;
                if (r_samp_pend && !w_start_sample && (r_drop != 8'hFF)) begin
                    r_drop <= r_drop + 8'd1;
                end
            end else if (w_start_sample) begin
                r_samp_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_cnt      <= 16'd0;
            r_hdr      <= 8'h00;
            r_ftemp    <= 8'h00;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
            r_ack_err  <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_alarm || w_start_sample) begin
                        r_hdr      <= w_start_alarm ? HDR_ALARM : HDR_SAMPLE;
                        r_ftemp    <= w_start_alarm ? r_alarm_temp : r_samp_temp;
                        r_tx_data  <= w_start_alarm ? HDR_ALARM : HDR_SAMPLE;
                        r_idx      <= '0;
                        r_tx_start <= 1'b1;
                        r_state    <= ST_START;
                    end
                end
                ST_START: begin
                    r_cnt   <= 16'd0;
                    r_state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (tx.tx_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (r_cnt == c_TIMEOUT_LAST) begin
                        r_ack_err <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx.tx_busy) begin
                        if (r_idx == c_LAST_IDX) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx      <= w_next_idx;
                            r_tx_data  <= (w_next_idx == c_LAST_IDX) ? w_checksum : w_byte;
                            r_tx_start <= 1'b1;
                            r_state    <= ST_START;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign tx.tx_start   = r_tx_start;
    assign tx.tx_data    = r_tx_data;
    assign frame_active  = (r_state != ST_IDLE);
    assign drop_count    = r_drop;
    assign ack_error     = r_ack_err;

endmodule
`default_nettype wire
